// File: rtl/ioctl_loader.sv
// ioctl_loader: hps_io download manager routing target writes, DIP/mod capture, completion tracking and core reset.
// Optional LOADER_CHECKSUM_EN adds csum/csum_idx outputs with a per-download byte sum.
module ioctl_loader #(
  parameter int ADDR_W = 25,
  parameter int NUM_DIP = 8,
  parameter int DIP_INDEX = 254,
  parameter int MOD_INDEX = 1,
  parameter logic [7:0] REQ_MASK = 8'h05,
  parameter int HOLD_CYC = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [ADDR_W-1:0]    ioctl_addr,
  input  logic [7:0]           ioctl_dout,
  input  logic [7:0]           ioctl_index,
  output logic                 ioctl_wait,
  output logic                 tgt_wr,
  output logic [7:0]           tgt_sel,
  output logic [ADDR_W-1:0]    tgt_addr,
  output logic [7:0]           tgt_data,
  input  logic                 tgt_busy,
  output logic [NUM_DIP*8-1:0] dip_bank,
  output logic [7:0]           mod,
  output logic [7:0]           done_mask,
  output logic                 core_reset,
  output logic                 rom_download
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]          csum,
  output logic [7:0]           csum_idx
`endif
);
  localparam int CW = $clog2(HOLD_CYC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [1:0] r_rst_sync;
  logic w_rst_n, w_dip_wr, w_mod_wr, w_tgt_cls, w_tgt_acc, w_mark, w_fall, w_hold;
  logic r_dl_d;
  logic [7:0] r_written, w_set;
  logic [7:0] r_dip [NUM_DIP];
  logic [CW-1:0] r_cnt;
  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) r_rst_sync <= '0;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  assign w_rst_n = r_rst_sync[1];
  assign w_dip_wr = w_rst_n && ioctl_wr && ioctl_index == 8'(DIP_INDEX);
  assign w_mod_wr = w_rst_n && ioctl_wr && ioctl_index == 8'(MOD_INDEX) && !w_dip_wr;
  assign w_tgt_cls = w_rst_n && ioctl_wr && ioctl_index < 8'd8 && !w_dip_wr && !w_mod_wr;
  assign w_tgt_acc = w_tgt_cls && r_state == IDLE;
  assign w_mark = w_tgt_acc || (w_mod_wr && ioctl_index < 8'd8);
  assign w_set = w_mark ? 8'(1) << ioctl_index[2:0] : 8'd0;
  assign w_fall = r_dl_d && !ioctl_download;
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state == IDLE ? (w_tgt_acc ? ISSUE : IDLE) : r_state == ISSUE ? WAIT : (tgt_busy ? WAIT : IDLE);
    ioctl_wait = r_state == IDLE ? w_tgt_acc : r_state == ISSUE ? 1'b1 : tgt_busy;
  end
  assign tgt_wr = r_state == ISSUE;
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) begin
      tgt_sel <= '0;
      tgt_addr <= '0;
      tgt_data <= '0;
    end else if (w_tgt_acc) begin
      tgt_sel <= 8'(1) << ioctl_index[2:0];
      tgt_addr <= ioctl_addr;
      tgt_data <= ioctl_dout;
    end
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) begin
      for (int k = 0; k < NUM_DIP; k++) r_dip[k] <= '0;
      mod <= '0;
    end else begin
      for (int k = 0; k < NUM_DIP; k++)
        if (w_dip_wr && ioctl_addr == ADDR_W'(k)) r_dip[k] <= ioctl_dout;
      if (w_mod_wr) mod <= ioctl_dout;
    end
  for (genvar k = 0; k < NUM_DIP; k++) begin : g_dip
    assign dip_bank[8*k +: 8] = r_dip[k];
  end
  // Written flags only reach done_mask when the download closes, so empty downloads never mark done.
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) begin
      r_dl_d <= 1'b0;
      r_written <= '0;
      done_mask <= '0;
    end else begin
      r_dl_d <= ioctl_download;
      r_written <= w_fall ? w_set : r_written | w_set;
      if (w_fall) done_mask <= done_mask | r_written;
    end
  assign w_hold = (done_mask & REQ_MASK) != REQ_MASK ||
                  (ioctl_download && ioctl_index < 8'd8 && REQ_MASK[ioctl_index[2:0]]);
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) r_cnt <= CW'(HOLD_CYC);
    else r_cnt <= w_hold ? CW'(HOLD_CYC) : (r_cnt != '0 ? r_cnt - 1'b1 : r_cnt);
  assign core_reset = w_hold || r_cnt != '0;
  assign rom_download = w_rst_n && ioctl_download && ioctl_index == 8'd0;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] r_sum;
  logic [7:0] r_idx;
  always_ff @(posedge clk_sys or negedge w_rst_n)
    if (!w_rst_n) begin
      r_sum <= '0;
      r_idx <= '0;
      csum <= '0;
      csum_idx <= '0;
    end else begin
      r_idx <= ioctl_download ? ioctl_index : r_idx;
      r_sum <= (w_fall ? 16'd0 : r_sum) + (w_tgt_acc ? 16'(ioctl_dout) : 16'd0);
      if (w_fall) begin
        csum <= r_sum;
        csum_idx <= r_idx;
      end
    end
`endif
endmodule

// File: tb/tb_ioctl_loader.sv
// tb_ioctl_loader: directed self-checking bench for ioctl_loader (default parameters).
module tb_ioctl_loader;
  logic clk_sys = 0, reset_n = 0, ioctl_download = 0, ioctl_wr = 0, tgt_busy = 0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0] ioctl_dout = '0, ioctl_index = '0;
  logic ioctl_wait, tgt_wr, core_reset, rom_download;
  logic [7:0] tgt_sel, tgt_data, mod, done_mask;
  logic [24:0] tgt_addr;
  logic [63:0] dip_bank;
  int tests = 0, fails = 0;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0] csum;
  logic [7:0] csum_idx;
`endif
  ioctl_loader dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .ioctl_wait(ioctl_wait), .tgt_wr(tgt_wr), .tgt_sel(tgt_sel), .tgt_addr(tgt_addr),
    .tgt_data(tgt_data), .tgt_busy(tgt_busy), .dip_bank(dip_bank), .mod(mod),
    .done_mask(done_mask), .core_reset(core_reset), .rom_download(rom_download)
`ifdef LOADER_CHECKSUM_EN
    , .csum(csum), .csum_idx(csum_idx)
`endif
  );
  always #5 clk_sys = ~clk_sys;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic write_one(input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_wr = 1; ioctl_dout = d;
    @(negedge clk_sys);
    ioctl_wr = 0;
    repeat (2) @(negedge clk_sys);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk_sys);
    tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL reset_core_reset_in_reset got %b want 1", core_reset); end
    reset_n = 1;
    repeat (5) @(negedge clk_sys);
    tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL reset_core_reset got %b want 1", core_reset); end
    tests++; if (ioctl_wait !== 1'b0) begin fails++; $display("FAIL reset_wait got %b want 0", ioctl_wait); end
    tests++; if (tgt_wr !== 1'b0 || tgt_sel !== 8'h00) begin fails++; $display("FAIL reset_tgt got wr=%b sel=%h want 0/00", tgt_wr, tgt_sel); end
    tests++; if (done_mask !== 8'h00 || mod !== 8'h00 || dip_bank !== 64'h0) begin fails++; $display("FAIL reset_regs got done=%h mod=%h dip=%h want 0", done_mask, mod, dip_bank); end
    tests++; if (rom_download !== 1'b0) begin fails++; $display("FAIL reset_rom_download got %b want 0", rom_download); end
  endtask
  task automatic test_dip;
    int waits = 0;
    @(negedge clk_sys);
    ioctl_index = 8'd254; ioctl_download = 1;
    for (int a = 0; a < 10; a++) begin
      @(negedge clk_sys);
      ioctl_wr = 1; ioctl_addr = 25'(a); ioctl_dout = 8'(10 + a);
      #1 if (ioctl_wait) waits++;
      @(negedge clk_sys);
      ioctl_wr = 0;
    end
    ioctl_download = 0;
    repeat (2) @(negedge clk_sys);
    tests++; if (dip_bank !== 64'h11100F0E0D0C0B0A) begin fails++; $display("FAIL dip_bank got %h want 11100f0e0d0c0b0a", dip_bank); end
    tests++; if (waits !== 0) begin fails++; $display("FAIL dip_no_wait got %0d stalled cycles want 0", waits); end
    tests++; if (done_mask !== 8'h00) begin fails++; $display("FAIL dip_done got %h want 00", done_mask); end
  endtask
  task automatic test_target;
    int waits = 0, pulses = 0, pulse_at = -1;
    @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_download = 1;
    #1 tests++; if (rom_download !== 1'b1) begin fails++; $display("FAIL rom_download got %b want 1", rom_download); end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_sys);
      ioctl_wr = n == 0; ioctl_addr = 25'h123; ioctl_dout = 8'hA5;
      tgt_busy = n >= 2 && n <= 4;
      #1;
      if (ioctl_wait) waits++;
      if (tgt_wr) begin pulses++; pulse_at = n; end
      if (n == 1) begin
        tests++; if (tgt_sel !== 8'h01 || tgt_addr !== 25'h123 || tgt_data !== 8'hA5) begin fails++; $display("FAIL target_latch got sel=%h addr=%h data=%h want 01/123/a5", tgt_sel, tgt_addr, tgt_data); end
      end
    end
    ioctl_wr = 0; tgt_busy = 0;
    tests++; if (pulses !== 1 || pulse_at !== 1) begin fails++; $display("FAIL target_pulse got %0d pulses at %0d want 1 at 1", pulses, pulse_at); end
    tests++; if (waits !== 5) begin fails++; $display("FAIL target_wait got %0d cycles want 5", waits); end
  endtask
  task automatic test_back_to_back;
    int waits = 0, pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk_sys);
      ioctl_wr = n < 2; ioctl_addr = n == 0 ? 25'h10 : 25'h20; ioctl_dout = n == 0 ? 8'h01 : 8'h02;
      #1;
      if (ioctl_wait) waits++;
      if (tgt_wr) pulses++;
    end
    ioctl_wr = 0;
    tests++; if (pulses !== 1 || tgt_addr !== 25'h10 || tgt_data !== 8'h01) begin fails++; $display("FAIL b2b_ignore got pulses=%0d addr=%h data=%h want 1/10/01", pulses, tgt_addr, tgt_data); end
    tests++; if (waits !== 2) begin fails++; $display("FAIL b2b_min_stall got %0d cycles want 2", waits); end
    @(negedge clk_sys);
    ioctl_download = 0;
    repeat (2) @(negedge clk_sys);
    tests++; if (done_mask !== 8'h01) begin fails++; $display("FAIL done_idx0 got %h want 01", done_mask); end
    tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL core_reset_partial got %b want 1", core_reset); end
  endtask
  task automatic test_completion;
    int n = 0;
    @(negedge clk_sys);
    ioctl_index = 8'd2; ioctl_download = 1;
    write_one(8'h77);
    ioctl_download = 0;
    while (core_reset === 1'b1 && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    tests++; if (done_mask !== 8'h05) begin fails++; $display("FAIL done_both got %h want 05", done_mask); end
    tests++; if (n < 16 || n > 17) begin fails++; $display("FAIL hold_cycles got %0d want 16..17", n); end
  endtask
  task automatic test_zero_write;
    @(negedge clk_sys);
    ioctl_index = 8'd3; ioctl_download = 1;
    repeat (4) @(negedge clk_sys);
    tests++; if (core_reset !== 1'b0) begin fails++; $display("FAIL unreq_download_reset got %b want 0", core_reset); end
    ioctl_download = 0;
    repeat (3) @(negedge clk_sys);
    tests++; if (done_mask !== 8'h05) begin fails++; $display("FAIL zero_write_done got %h want 05", done_mask); end
    ioctl_index = 8'd0; ioctl_download = 1;
    #1 tests++; if (core_reset !== 1'b1) begin fails++; $display("FAIL req_download_reset got %b want 1", core_reset); end
    @(negedge clk_sys);
    ioctl_download = 0;
    @(negedge clk_sys);
  endtask
  task automatic test_reset_mid;
    @(negedge clk_sys);
    ioctl_index = 8'd0; ioctl_download = 1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_sys);
      ioctl_wr = n == 0; tgt_busy = n >= 1;
    end
    ioctl_wr = 0;
    #1 tests++; if (ioctl_wait !== 1'b1) begin fails++; $display("FAIL mid_wait_before got %b want 1", ioctl_wait); end
    reset_n = 0;
    #1;
    tests++; if (tgt_wr !== 1'b0 || ioctl_wait !== 1'b0) begin fails++; $display("FAIL mid_reset_tgt got wr=%b wait=%b want 0/0", tgt_wr, ioctl_wait); end
    tests++; if (done_mask !== 8'h00 || core_reset !== 1'b1) begin fails++; $display("FAIL mid_reset_state got done=%h core_reset=%b want 00/1", done_mask, core_reset); end
    @(negedge clk_sys);
    reset_n = 1; tgt_busy = 0; ioctl_download = 0;
    repeat (4) @(negedge clk_sys);
    tests++; if (dip_bank !== 64'h0) begin fails++; $display("FAIL mid_reset_dip got %h want 0", dip_bank); end
  endtask
`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    @(negedge clk_sys);
    ioctl_index = 8'd2; ioctl_download = 1;
    write_one(8'hFF);
    write_one(8'hFF);
    write_one(8'h02);
    ioctl_download = 0;
    repeat (3) @(negedge clk_sys);
    tests++; if (csum !== 16'h0200 || csum_idx !== 8'd2) begin fails++; $display("FAIL checksum got %h idx %0d want 0200 idx 2", csum, csum_idx); end
  endtask
`endif
  task automatic test_mod;
    int waits = 0;
    @(negedge clk_sys);
    ioctl_index = 8'd1; ioctl_download = 1;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk_sys);
      ioctl_wr = 1; ioctl_dout = n == 0 ? 8'h33 : 8'h5A;
      #1 if (ioctl_wait) waits++;
      @(negedge clk_sys);
      ioctl_wr = 0;
    end
    ioctl_download = 0;
    @(negedge clk_sys);
    tests++; if (mod !== 8'h5A) begin fails++; $display("FAIL mod_last_wins got %h want 5a", mod); end
    tests++; if (waits !== 0) begin fails++; $display("FAIL mod_no_wait got %0d want 0", waits); end
  endtask
  initial begin
    test_reset;
    test_dip;
    test_target;
    test_back_to_back;
    test_completion;
    test_zero_write;
    test_reset_mid;
`ifdef LOADER_CHECKSUM_EN
    test_checksum;
`endif
    test_mod;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
Parametrised download manager between hps_io ioctl signals and the arcade core. It routes ROM, wave and other indexed downloads to a target memory through a wait/busy handshake, and captures the DIP bank and the game-select (mod) byte. It tracks per-index download completion and generates a core reset that is held until every required index has loaded. It replaces the ad-hoc download_complete, DIP and mod capture logic in emu tops, and supports a configurable DIP depth and required-index set.

Parameters:
ADDR_W, 25, ioctl/target address width
NUM_DIP, 8, DIP bytes captured (1..16)
DIP_INDEX, 254, ioctl_index for DIP data
MOD_INDEX, 1, ioctl_index for game-select byte
REQ_MASK, 8'h05, bit i set = index i must complete before reset releases (indices 0..7)
HOLD_CYC, 16, core_reset extension after requirements met (>=1)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  download active
ioctl_wr  in  1  write strobe, one cycle
ioctl_addr  in  ADDR_W  byte address
ioctl_dout  in  8  write data
ioctl_index  in  8  download index
ioctl_wait  out  1  stall to hps_io
tgt_wr  out  1  one-cycle target write pulse
tgt_sel  out  8  one-hot target index, valid with tgt_wr
tgt_addr  out  ADDR_W  latched address
tgt_data  out  8  latched data
tgt_busy  in  1  target still completing write
dip_bank  out  NUM_DIP*8  DIP bytes, byte k at [8k+7:8k]
mod  out  8  game-select byte
done_mask  out  8  completed indices 0..7
core_reset  out  1  active-high reset to core
rom_download  out  1  ioctl_download && index==0

Behaviour:
- Reset (reset_n low, any time, including mid-transfer): all outputs 0 except core_reset=1; dip_bank=0, mod=0, done_mask=0; FSM returns to IDLE. Asynchronous assertion, synchronous release.
- Write classes on ioctl_wr:
  - index==DIP_INDEX and addr < NUM_DIP: dip_bank byte[addr] <= dout next edge; higher addresses ignored; no stall.
  - index==MOD_INDEX: mod <= dout, last write wins; no stall.
  - index<8 (and not DIP/MOD): target write through the FSM.
  - Any other index: ignored.
- Target FSM, states IDLE -> ISSUE -> WAIT -> IDLE:
  - IDLE: on a target-class ioctl_wr, latch addr/data/sel and go to ISSUE. ioctl_wait is asserted combinationally that same cycle.
  - ISSUE: tgt_wr=1 for exactly one cycle; ioctl_wait=1; go to WAIT.
  - WAIT: ioctl_wait=1 while tgt_busy=1. First cycle with tgt_busy=0 -> IDLE, ioctl_wait=0.
  - Minimum write latency: tgt_wr appears 1 cycle after ioctl_wr. Minimum stall: 2 cycles.
  - ioctl_wr arriving outside IDLE is a protocol violation: ignored, and no second pulse is issued.
- Completion:
  - A per-index "written" flag is set by any accepted write for indices 0..7.
  - On the falling edge of ioctl_download (registered), done_mask[index] <= written flag; written flags then clear.
  - A download with zero writes does not set done. done bits never clear except on reset_n.
- core_reset:
  - High while (done_mask & REQ_MASK) != REQ_MASK.
  - High while ioctl_download is active with an index in REQ_MASK.
  - Otherwise high for HOLD_CYC further cycles, counting from the cycle requirements became met; the counter restarts if the condition re-asserts. Then 0.
  - REQ_MASK=0: core_reset is held only for HOLD_CYC cycles after reset_n release.

Optional Feature:
LOADER_CHECKSUM_EN. When defined:
- Adds output csum (16 bits) and csum_idx (8 bits).
- A running 16-bit wrap-around sum of ioctl_dout is kept over accepted target writes of the current download.
- On download end it is latched into csum with csum_idx = index; both reset to 0.
When undefined, these ports and the logic are absent.

Test Plan:
- Reset release, no downloads, REQ_MASK=05 -> core_reset stays 1, ioctl_wait 0, outputs 0.
- DIP download, addr 0..9 with data 10..19, NUM_DIP=8 -> dip_bank bytes 0..7 = 10..17; addr 8,9 ignored; no ioctl_wait.
- Index 0 write, addr 0x123, data 0xA5, tgt_busy high 3 cycles -> tgt_wr one pulse at +1 with sel=01, addr 0x123, data A5; ioctl_wait high exactly 5 cycles.
- Download index 0 then index 2 (≥1 write each) -> done_mask=05; core_reset falls HOLD_CYC=16 cycles after index 2 download ends.
- reset_n pulsed low during WAIT -> tgt_wr=0, ioctl_wait=0, done_mask=0, core_reset=1 immediately.
- LOADER_CHECKSUM_EN, index 2 bytes FF,FF,02 -> csum=0x0200, csum_idx=2 after download ends.
